ram_test_sequencer: RTL and testbench

- Upstream traffic generator and checker for the 16x16 RAM controller in ram_qsys.
- Drives its addr/w_en/r_en/data_in conduits and consumes its data_out.
- On a start pulse it runs two passes, pattern then inverted pattern: write all 16 words, read them back, compare.
- Reports done, pass/fail, error count and the location of the first error.

---
 rtl/ram_test_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_ram_test_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ram_test_sequencer.sv
// rtl/ram_test_sequencer.sv - two-pass write/read/compare traffic generator for the 16x16 RAM controller
module ram_test_sequencer #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] addr_out,
    output logic              w_en_out,
    output logic              r_en_out,
    output logic [DATA_W-1:0] data_wr_out,
    input  logic [DATA_W-1:0] data_rd_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [5:0]        err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_pass
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] ADDR_LAST  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] DRAIN_LAST = ADDR_W'(READ_LATENCY - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              pass_idx_q, pass_idx_d;
    logic [DATA_W-1:0] seed_q, seed_d;

    logic              w_en_q, w_en_d;
    logic              r_en_q, r_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [5:0]        err_q, err_d;
    logic [ADDR_W-1:0] fea_q, fea_d;
    logic              fep_q, fep_d;

    // Expected-value pipeline; stage 0 lines up with the registered r_en_out cycle.
    logic [READ_LATENCY-1:0] vld_q;
    logic [ADDR_W-1:0]       pa_q [READ_LATENCY];
    logic [DATA_W-1:0]       pe_q [READ_LATENCY];
    logic                    pp_q [READ_LATENCY];

    logic accept;
    logic mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [DATA_W-1:0] p;
        p = seed_q ^ {(DATA_W / ADDR_W){a}};
        return inv ? ~p : p;
    endfunction

    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch = vld_q[READ_LATENCY-1] && (data_rd_in != pe_q[READ_LATENCY-1]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pass_idx_d = pass_idx_q;
        seed_d     = seed_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d    = ST_WRITE;
                    cnt_d      = '0;
                    pass_idx_d = 1'b0;
                    seed_d     = seed;
                end
            end
            ST_WRITE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) state_d = ST_READ;
            end
            ST_READ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_LAST) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d = '0;
                    if (pass_idx_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_WRITE;
                        pass_idx_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM-side outputs are a registered image of the current state, so they trail it by one cycle.
    always_comb begin
        w_en_d = 1'b0;
        r_en_d = 1'b0;
        addr_d = '0;
        data_d = '0;
        if (state_q == ST_WRITE) begin
            w_en_d = 1'b1;
            addr_d = cnt_q;
            data_d = pattern(cnt_q, pass_idx_q);
        end else if (state_q == ST_READ) begin
            r_en_d = 1'b1;
            addr_d = cnt_q;
        end
    end

    always_comb begin
        err_d  = err_q;
        fea_d  = fea_q;
        fep_d  = fep_q;
        busy_d = busy_q;
        done_d = done_q;
        if (accept) begin
            err_d  = '0;
            fea_d  = '0;
            fep_d  = 1'b0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else begin
            if (mismatch) begin
                err_d = err_q + 1'b1;
                if (err_q == '0) begin
                    fea_d = pa_q[READ_LATENCY-1];
                    fep_d = pp_q[READ_LATENCY-1];
                end
            end
            if (state_q == ST_DONE) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pass_idx_q <= 1'b0;
            seed_q     <= '0;
            w_en_q     <= 1'b0;
            r_en_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
            fea_q      <= '0;
            fep_q      <= 1'b0;
            vld_q      <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pa_q[i] <= '0;
                pe_q[i] <= '0;
                pp_q[i] <= 1'b0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pass_idx_q <= pass_idx_d;
            seed_q     <= seed_d;
            w_en_q     <= w_en_d;
            r_en_q     <= r_en_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            fea_q      <= fea_d;
            fep_q      <= fep_d;
            vld_q[0]   <= r_en_q;
            pa_q[0]    <= addr_q;
            pe_q[0]    <= pattern(addr_q, pass_idx_q);
            pp_q[0]    <= pass_idx_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
                pe_q[i]  <= pe_q[i-1];
                pp_q[i]  <= pp_q[i-1];
            end
        end
    end

    assign addr_out       = addr_q;
    assign w_en_out       = w_en_q;
    assign r_en_out       = r_en_q;
    assign data_wr_out    = data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = done_q && (err_q == '0);
    assign err_count      = err_q;
    assign first_err_addr = fea_q;
    assign first_err_pass = fep_q;

endmodule

// File: tb/tb_ram_test_sequencer.sv
// tb/tb_ram_test_sequencer.sv - directed bench with 1- and 2-cycle RAM models
module tb_ram_test_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] seed;
    logic        start1, start2;
    logic        fault;

    logic [3:0]  a1, a2, fa1, fa2;
    logic        we1, we2, re1, re2, busy1, busy2, done1, done2, ps1, ps2, fp1, fp2;
    logic [15:0] wd1, wd2, rd1, rd2, r2a;
    logic [5:0]  ec1, ec2;
    logic [15:0] mem1 [16];
    logic [15:0] mem2 [16];

    ram_test_sequencer #(.READ_LATENCY(1)) u_dut1 (
        .clk_clk(clk), .reset_reset(rst), .start(start1), .seed(seed),
        .addr_out(a1), .w_en_out(we1), .r_en_out(re1), .data_wr_out(wd1), .data_rd_in(rd1),
        .busy(busy1), .done(done1), .pass(ps1), .err_count(ec1),
        .first_err_addr(fa1), .first_err_pass(fp1)
    );

    ram_test_sequencer #(.READ_LATENCY(2)) u_dut2 (
        .clk_clk(clk), .reset_reset(rst), .start(start2), .seed(seed),
        .addr_out(a2), .w_en_out(we2), .r_en_out(re2), .data_wr_out(wd2), .data_rd_in(rd2),
        .busy(busy2), .done(done2), .pass(ps2), .err_count(ec2),
        .first_err_addr(fa2), .first_err_pass(fp2)
    );

    // RAM models: one-cycle read with optional stuck-at-0 on bit 3 of word 5; ideal two-cycle read.
    always @(posedge clk) begin
        if (we1) mem1[a1] <= wd1;
        if (re1) rd1 <= (fault && a1 == 4'd5) ? (mem1[a1] & ~16'h0008) : mem1[a1];
        if (we2) mem2[a2] <= wd2;
        if (re2) r2a <= mem2[a2];
        rd2 <= r2a;
    end

    logic        sel;
    logic        v_we, v_re, v_busy, v_done;
    logic [3:0]  v_addr;
    logic [15:0] v_wd;
    assign v_we   = sel ? we2   : we1;
    assign v_re   = sel ? re2   : re1;
    assign v_busy = sel ? busy2 : busy1;
    assign v_done = sel ? done2 : done1;
    assign v_addr = sel ? a2    : a1;
    assign v_wd   = sel ? wd2   : wd1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [15:0] wq [$];
    int          first_wr;
    int          done_k;

    task automatic run(input logic s, input logic [15:0] sd, input bit poke);
        int k, excl, bd, idle_bad;
        sel = s;
        wq.delete();
        excl = 0; bd = 0; idle_bad = 0; first_wr = -1;
        @(negedge clk);
        seed = sd;
        if (s) start2 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        check("busy_after_start", {v_busy, v_done}, 2'b10);
        k = 0;
        while (!v_done && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (v_we && first_wr < 0) first_wr = k;
            if (v_we && v_addr == 4'd5) wq.push_back(v_wd);
            if (v_we && v_re) excl++;
            if (v_busy && v_done) bd++;
            if (!v_we && !v_re && (v_addr != 4'd0 || v_wd != 16'd0)) idle_bad++;
            if (poke) begin
                start1 = (k == 3 || k == 40) && !s;
                start2 = (k == 3 || k == 40) && s;
            end
        end
        start1 = 1'b0; start2 = 1'b0;
        done_k = k;
        check("done_reached", v_done, 1'b1);
        check("first_write_edge", first_wr, 1);
        check("run_length", done_k - first_wr, s ? 68 : 66);
        check("no_overlap", excl + bd, 0);
        check("idle_zero", idle_bad, 0);
        check("addr5_writes", wq.size(), 2);
    endtask

    initial begin
        int k;
        rst = 1'b1; seed = '0; start1 = 1'b0; start2 = 1'b0; fault = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs1", {a1, we1, re1, wd1, busy1, done1, ps1, ec1, fa1, fp1}, '0);
        check("reset_outs2", {a2, we2, re2, wd2, busy2, done2, ps2, ec2, fa2, fp2}, '0);
        @(negedge clk); rst = 1'b0;

        run(1'b0, 16'h0000, 1'b0);
        check("s1_wr5_p0", wq.size() > 0 ? wq[0] : 16'hxxxx, 16'h5555);
        check("s1_wr5_p1", wq.size() > 1 ? wq[1] : 16'hxxxx, 16'hAAAA);
        check("s1_result", {ps1, ec1}, {1'b1, 6'd0});

        fault = 1'b1;
        run(1'b0, 16'h0008, 1'b0);
        fault = 1'b0;
        check("s2_wr5_p0", wq.size() > 0 ? wq[0] : 16'hxxxx, 16'h555D);
        check("s2_result", {ps1, ec1, fa1, fp1}, {1'b0, 6'd1, 4'd5, 1'b0});

        run(1'b0, 16'h0000, 1'b1);
        check("s3_result", {ps1, ec1, fa1, fp1}, {1'b1, 6'd0, 4'd0, 1'b0});

        // Abort at write address 7, then confirm the RAM stays untouched.
        sel = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        while (!(we1 && a1 == 4'd7) && k < 50) begin
            @(posedge clk); #1; k++;
        end
        check("reached_wr7", {we1, a1}, {1'b1, 4'd7});
        @(negedge clk); rst = 1'b1; #1;
        check("abort_outs", {a1, we1, re1, wd1, busy1, done1, ps1, ec1, fa1, fp1}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (we1 || re1 || busy1) k++;
        end
        check("quiet_after_abort", k, 0);
        run(1'b0, 16'h1234, 1'b0);
        check("s4_result", {ps1, ec1}, {1'b1, 6'd0});

        run(1'b1, 16'h0000, 1'b0);
        check("s5_result", {ps2, ec2}, {1'b1, 6'd0});
        run(1'b1, 16'hFFFF, 1'b0);
        check("s6_wr5_p0", wq.size() > 0 ? wq[0] : 16'hxxxx, 16'hAAAA);
        check("s6_wr5_p1", wq.size() > 1 ? wq[1] : 16'hxxxx, 16'h5555);
        check("s6_result", {ps2, ec2, fa2, fp2}, {1'b1, 6'd0, 4'd0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
